// File: rtl/out_port.sv
// Egress port: buffers final-stage PHV beats in a DEPTH-entry FIFO and drives
// them onto the 1024-bit egress stream with valid/ready handshaking.
module out_port #(
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [7:0]    io_phv_in_data_0,   io_phv_in_data_1,   io_phv_in_data_2,   io_phv_in_data_3,
                         io_phv_in_data_4,   io_phv_in_data_5,   io_phv_in_data_6,   io_phv_in_data_7,
                         io_phv_in_data_8,   io_phv_in_data_9,   io_phv_in_data_10,  io_phv_in_data_11,
                         io_phv_in_data_12,  io_phv_in_data_13,  io_phv_in_data_14,  io_phv_in_data_15,
                         io_phv_in_data_16,  io_phv_in_data_17,  io_phv_in_data_18,  io_phv_in_data_19,
                         io_phv_in_data_20,  io_phv_in_data_21,  io_phv_in_data_22,  io_phv_in_data_23,
                         io_phv_in_data_24,  io_phv_in_data_25,  io_phv_in_data_26,  io_phv_in_data_27,
                         io_phv_in_data_28,  io_phv_in_data_29,  io_phv_in_data_30,  io_phv_in_data_31,
                         io_phv_in_data_32,  io_phv_in_data_33,  io_phv_in_data_34,  io_phv_in_data_35,
                         io_phv_in_data_36,  io_phv_in_data_37,  io_phv_in_data_38,  io_phv_in_data_39,
                         io_phv_in_data_40,  io_phv_in_data_41,  io_phv_in_data_42,  io_phv_in_data_43,
                         io_phv_in_data_44,  io_phv_in_data_45,  io_phv_in_data_46,  io_phv_in_data_47,
                         io_phv_in_data_48,  io_phv_in_data_49,  io_phv_in_data_50,  io_phv_in_data_51,
                         io_phv_in_data_52,  io_phv_in_data_53,  io_phv_in_data_54,  io_phv_in_data_55,
                         io_phv_in_data_56,  io_phv_in_data_57,  io_phv_in_data_58,  io_phv_in_data_59,
                         io_phv_in_data_60,  io_phv_in_data_61,  io_phv_in_data_62,  io_phv_in_data_63,
                         io_phv_in_data_64,  io_phv_in_data_65,  io_phv_in_data_66,  io_phv_in_data_67,
                         io_phv_in_data_68,  io_phv_in_data_69,  io_phv_in_data_70,  io_phv_in_data_71,
                         io_phv_in_data_72,  io_phv_in_data_73,  io_phv_in_data_74,  io_phv_in_data_75,
                         io_phv_in_data_76,  io_phv_in_data_77,  io_phv_in_data_78,  io_phv_in_data_79,
                         io_phv_in_data_80,  io_phv_in_data_81,  io_phv_in_data_82,  io_phv_in_data_83,
                         io_phv_in_data_84,  io_phv_in_data_85,  io_phv_in_data_86,  io_phv_in_data_87,
                         io_phv_in_data_88,  io_phv_in_data_89,  io_phv_in_data_90,  io_phv_in_data_91,
                         io_phv_in_data_92,  io_phv_in_data_93,  io_phv_in_data_94,  io_phv_in_data_95,
                         io_phv_in_data_96,  io_phv_in_data_97,  io_phv_in_data_98,  io_phv_in_data_99,
                         io_phv_in_data_100, io_phv_in_data_101, io_phv_in_data_102, io_phv_in_data_103,
                         io_phv_in_data_104, io_phv_in_data_105, io_phv_in_data_106, io_phv_in_data_107,
                         io_phv_in_data_108, io_phv_in_data_109, io_phv_in_data_110, io_phv_in_data_111,
                         io_phv_in_data_112, io_phv_in_data_113, io_phv_in_data_114, io_phv_in_data_115,
                         io_phv_in_data_116, io_phv_in_data_117, io_phv_in_data_118, io_phv_in_data_119,
                         io_phv_in_data_120, io_phv_in_data_121, io_phv_in_data_122, io_phv_in_data_123,
                         io_phv_in_data_124, io_phv_in_data_125, io_phv_in_data_126, io_phv_in_data_127,
   input  logic          io_phv_in_valid,
   input  logic          io_phv_in_last,
   output logic          io_phv_in_ready,
   input  logic          io_ready,
   output logic          io_en,
   output logic          io_last,
   output logic [1023:0] io_data,
   output logic [15:0]   io_pkt_cnt,
   output logic          io_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [1024:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic [15:0]   r_pkt_cnt;
   logic          r_overflow, r_prev_stall;
   logic [1024:0] r_prev_beat;

   logic [1024:0] w_beat, w_head;
   logic          w_push, w_pop, w_stall;

   // Lane 0 lands in the most significant byte of the egress word.
   assign w_beat = {io_phv_in_last,
      io_phv_in_data_0,   io_phv_in_data_1,   io_phv_in_data_2,   io_phv_in_data_3,   io_phv_in_data_4,   io_phv_in_data_5,   io_phv_in_data_6,   io_phv_in_data_7,
      io_phv_in_data_8,   io_phv_in_data_9,   io_phv_in_data_10,  io_phv_in_data_11,  io_phv_in_data_12,  io_phv_in_data_13,  io_phv_in_data_14,  io_phv_in_data_15,
      io_phv_in_data_16,  io_phv_in_data_17,  io_phv_in_data_18,  io_phv_in_data_19,  io_phv_in_data_20,  io_phv_in_data_21,  io_phv_in_data_22,  io_phv_in_data_23,
      io_phv_in_data_24,  io_phv_in_data_25,  io_phv_in_data_26,  io_phv_in_data_27,  io_phv_in_data_28,  io_phv_in_data_29,  io_phv_in_data_30,  io_phv_in_data_31,
      io_phv_in_data_32,  io_phv_in_data_33,  io_phv_in_data_34,  io_phv_in_data_35,  io_phv_in_data_36,  io_phv_in_data_37,  io_phv_in_data_38,  io_phv_in_data_39,
      io_phv_in_data_40,  io_phv_in_data_41,  io_phv_in_data_42,  io_phv_in_data_43,  io_phv_in_data_44,  io_phv_in_data_45,  io_phv_in_data_46,  io_phv_in_data_47,
      io_phv_in_data_48,  io_phv_in_data_49,  io_phv_in_data_50,  io_phv_in_data_51,  io_phv_in_data_52,  io_phv_in_data_53,  io_phv_in_data_54,  io_phv_in_data_55,
      io_phv_in_data_56,  io_phv_in_data_57,  io_phv_in_data_58,  io_phv_in_data_59,  io_phv_in_data_60,  io_phv_in_data_61,  io_phv_in_data_62,  io_phv_in_data_63,
      io_phv_in_data_64,  io_phv_in_data_65,  io_phv_in_data_66,  io_phv_in_data_67,  io_phv_in_data_68,  io_phv_in_data_69,  io_phv_in_data_70,  io_phv_in_data_71,
      io_phv_in_data_72,  io_phv_in_data_73,  io_phv_in_data_74,  io_phv_in_data_75,  io_phv_in_data_76,  io_phv_in_data_77,  io_phv_in_data_78,  io_phv_in_data_79,
      io_phv_in_data_80,  io_phv_in_data_81,  io_phv_in_data_82,  io_phv_in_data_83,  io_phv_in_data_84,  io_phv_in_data_85,  io_phv_in_data_86,  io_phv_in_data_87,
      io_phv_in_data_88,  io_phv_in_data_89,  io_phv_in_data_90,  io_phv_in_data_91,  io_phv_in_data_92,  io_phv_in_data_93,  io_phv_in_data_94,  io_phv_in_data_95,
      io_phv_in_data_96,  io_phv_in_data_97,  io_phv_in_data_98,  io_phv_in_data_99,  io_phv_in_data_100, io_phv_in_data_101, io_phv_in_data_102, io_phv_in_data_103,
      io_phv_in_data_104, io_phv_in_data_105, io_phv_in_data_106, io_phv_in_data_107, io_phv_in_data_108, io_phv_in_data_109, io_phv_in_data_110, io_phv_in_data_111,
      io_phv_in_data_112, io_phv_in_data_113, io_phv_in_data_114, io_phv_in_data_115, io_phv_in_data_116, io_phv_in_data_117, io_phv_in_data_118, io_phv_in_data_119,
      io_phv_in_data_120, io_phv_in_data_121, io_phv_in_data_122, io_phv_in_data_123, io_phv_in_data_124, io_phv_in_data_125, io_phv_in_data_126, io_phv_in_data_127};

   assign io_phv_in_ready = (r_count < FULL);
   assign io_en           = (r_count != '0);
   assign w_head          = r_mem[r_rd_ptr];
   assign io_last         = w_head[1024];
   assign io_data         = w_head[1023:0];
   assign io_pkt_cnt      = r_pkt_cnt;
   assign io_overflow     = r_overflow;

   assign w_push  = io_phv_in_valid & io_phv_in_ready;
   assign w_pop   = io_en & io_ready;
   assign w_stall = io_phv_in_valid & ~io_phv_in_ready;

   // Entry 0 is cleared so the idle output bus reads zero after reset.
   always_ff @(posedge clock) begin
      if (!reset)      r_mem[0]        <= '0;
      else if (w_push) r_mem[r_wr_ptr] <= w_beat;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pkt_cnt  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         if (w_pop && w_head[1024]) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
   end

   // A stalled source must hold its beat; any change across two stalled cycles is sticky-flagged.
   always_ff @(posedge clock) begin
      r_prev_beat <= w_beat;
      if (!reset) begin
         r_prev_stall <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_prev_stall <= w_stall;
         if (w_stall && r_prev_stall && (w_beat != r_prev_beat)) r_overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_out_port.sv
// Directed self-checking bench for out_port: reset, latency, backpressure,
// streaming, push/pop at full, counter wrap, mid-packet reset and overflow flag.
module tb_out_port;
   logic          clock, reset;
   logic [7:0]    lanes [128];
   logic          io_phv_in_valid, io_phv_in_last, io_phv_in_ready;
   logic          io_ready, io_en, io_last, io_overflow;
   logic [1023:0] io_data;
   logic [15:0]   io_pkt_cnt;
   int            n_checks = 0;
   int            n_fail   = 0;

   out_port #(.DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .io_phv_in_data_0(lanes[0]),     .io_phv_in_data_1(lanes[1]),     .io_phv_in_data_2(lanes[2]),     .io_phv_in_data_3(lanes[3]),
      .io_phv_in_data_4(lanes[4]),     .io_phv_in_data_5(lanes[5]),     .io_phv_in_data_6(lanes[6]),     .io_phv_in_data_7(lanes[7]),
      .io_phv_in_data_8(lanes[8]),     .io_phv_in_data_9(lanes[9]),     .io_phv_in_data_10(lanes[10]),   .io_phv_in_data_11(lanes[11]),
      .io_phv_in_data_12(lanes[12]),   .io_phv_in_data_13(lanes[13]),   .io_phv_in_data_14(lanes[14]),   .io_phv_in_data_15(lanes[15]),
      .io_phv_in_data_16(lanes[16]),   .io_phv_in_data_17(lanes[17]),   .io_phv_in_data_18(lanes[18]),   .io_phv_in_data_19(lanes[19]),
      .io_phv_in_data_20(lanes[20]),   .io_phv_in_data_21(lanes[21]),   .io_phv_in_data_22(lanes[22]),   .io_phv_in_data_23(lanes[23]),
      .io_phv_in_data_24(lanes[24]),   .io_phv_in_data_25(lanes[25]),   .io_phv_in_data_26(lanes[26]),   .io_phv_in_data_27(lanes[27]),
      .io_phv_in_data_28(lanes[28]),   .io_phv_in_data_29(lanes[29]),   .io_phv_in_data_30(lanes[30]),   .io_phv_in_data_31(lanes[31]),
      .io_phv_in_data_32(lanes[32]),   .io_phv_in_data_33(lanes[33]),   .io_phv_in_data_34(lanes[34]),   .io_phv_in_data_35(lanes[35]),
      .io_phv_in_data_36(lanes[36]),   .io_phv_in_data_37(lanes[37]),   .io_phv_in_data_38(lanes[38]),   .io_phv_in_data_39(lanes[39]),
      .io_phv_in_data_40(lanes[40]),   .io_phv_in_data_41(lanes[41]),   .io_phv_in_data_42(lanes[42]),   .io_phv_in_data_43(lanes[43]),
      .io_phv_in_data_44(lanes[44]),   .io_phv_in_data_45(lanes[45]),   .io_phv_in_data_46(lanes[46]),   .io_phv_in_data_47(lanes[47]),
      .io_phv_in_data_48(lanes[48]),   .io_phv_in_data_49(lanes[49]),   .io_phv_in_data_50(lanes[50]),   .io_phv_in_data_51(lanes[51]),
      .io_phv_in_data_52(lanes[52]),   .io_phv_in_data_53(lanes[53]),   .io_phv_in_data_54(lanes[54]),   .io_phv_in_data_55(lanes[55]),
      .io_phv_in_data_56(lanes[56]),   .io_phv_in_data_57(lanes[57]),   .io_phv_in_data_58(lanes[58]),   .io_phv_in_data_59(lanes[59]),
      .io_phv_in_data_60(lanes[60]),   .io_phv_in_data_61(lanes[61]),   .io_phv_in_data_62(lanes[62]),   .io_phv_in_data_63(lanes[63]),
      .io_phv_in_data_64(lanes[64]),   .io_phv_in_data_65(lanes[65]),   .io_phv_in_data_66(lanes[66]),   .io_phv_in_data_67(lanes[67]),
      .io_phv_in_data_68(lanes[68]),   .io_phv_in_data_69(lanes[69]),   .io_phv_in_data_70(lanes[70]),   .io_phv_in_data_71(lanes[71]),
      .io_phv_in_data_72(lanes[72]),   .io_phv_in_data_73(lanes[73]),   .io_phv_in_data_74(lanes[74]),   .io_phv_in_data_75(lanes[75]),
      .io_phv_in_data_76(lanes[76]),   .io_phv_in_data_77(lanes[77]),   .io_phv_in_data_78(lanes[78]),   .io_phv_in_data_79(lanes[79]),
      .io_phv_in_data_80(lanes[80]),   .io_phv_in_data_81(lanes[81]),   .io_phv_in_data_82(lanes[82]),   .io_phv_in_data_83(lanes[83]),
      .io_phv_in_data_84(lanes[84]),   .io_phv_in_data_85(lanes[85]),   .io_phv_in_data_86(lanes[86]),   .io_phv_in_data_87(lanes[87]),
      .io_phv_in_data_88(lanes[88]),   .io_phv_in_data_89(lanes[89]),   .io_phv_in_data_90(lanes[90]),   .io_phv_in_data_91(lanes[91]),
      .io_phv_in_data_92(lanes[92]),   .io_phv_in_data_93(lanes[93]),   .io_phv_in_data_94(lanes[94]),   .io_phv_in_data_95(lanes[95]),
      .io_phv_in_data_96(lanes[96]),   .io_phv_in_data_97(lanes[97]),   .io_phv_in_data_98(lanes[98]),   .io_phv_in_data_99(lanes[99]),
      .io_phv_in_data_100(lanes[100]), .io_phv_in_data_101(lanes[101]), .io_phv_in_data_102(lanes[102]), .io_phv_in_data_103(lanes[103]),
      .io_phv_in_data_104(lanes[104]), .io_phv_in_data_105(lanes[105]), .io_phv_in_data_106(lanes[106]), .io_phv_in_data_107(lanes[107]),
      .io_phv_in_data_108(lanes[108]), .io_phv_in_data_109(lanes[109]), .io_phv_in_data_110(lanes[110]), .io_phv_in_data_111(lanes[111]),
      .io_phv_in_data_112(lanes[112]), .io_phv_in_data_113(lanes[113]), .io_phv_in_data_114(lanes[114]), .io_phv_in_data_115(lanes[115]),
      .io_phv_in_data_116(lanes[116]), .io_phv_in_data_117(lanes[117]), .io_phv_in_data_118(lanes[118]), .io_phv_in_data_119(lanes[119]),
      .io_phv_in_data_120(lanes[120]), .io_phv_in_data_121(lanes[121]), .io_phv_in_data_122(lanes[122]), .io_phv_in_data_123(lanes[123]),
      .io_phv_in_data_124(lanes[124]), .io_phv_in_data_125(lanes[125]), .io_phv_in_data_126(lanes[126]), .io_phv_in_data_127(lanes[127]),
      .io_phv_in_valid(io_phv_in_valid), .io_phv_in_last(io_phv_in_last), .io_phv_in_ready(io_phv_in_ready),
      .io_ready(io_ready), .io_en(io_en), .io_last(io_last), .io_data(io_data),
      .io_pkt_cnt(io_pkt_cnt), .io_overflow(io_overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Beat with seed s: lane k carries s+k.
   task automatic set_beat(input logic [7:0] s, input logic last);
      for (int k = 0; k < 128; k++) lanes[k] = s + 8'(k);
      io_phv_in_last = last;
   endtask

   function automatic logic [1023:0] exp_data(input logic [7:0] s);
      logic [1023:0] r;
      r = '0;
      for (int k = 0; k < 128; k++) r[1023-8*k -: 8] = s + 8'(k);
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; io_phv_in_valid = 1'b0; io_ready = 1'b0; set_beat(8'h00, 1'b0);
      tick(); tick();
      n_checks++; if (io_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", io_en); end
      n_checks++; if (io_phv_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", io_phv_in_ready); end
      n_checks++; if (io_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", io_last); end
      n_checks++; if (io_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", io_data); end
      n_checks++; if (io_pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %h want 0", io_pkt_cnt); end
      n_checks++; if (io_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", io_overflow); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_beat();
      io_ready = 1'b1; set_beat(8'h00, 1'b1); io_phv_in_valid = 1'b1;
      tick();
      io_phv_in_valid = 1'b0;
      n_checks++; if (io_en !== 1'b1) begin n_fail++; $display("FAIL single_en: got %b want 1", io_en); end
      n_checks++; if (io_data[1023:1016] !== 8'h00) begin n_fail++; $display("FAIL single_lane0: got %h want 00", io_data[1023:1016]); end
      n_checks++; if (io_data[7:0] !== 8'h7F) begin n_fail++; $display("FAIL single_lane127: got %h want 7f", io_data[7:0]); end
      n_checks++; if (io_last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", io_last); end
      tick();
      n_checks++; if (io_en !== 1'b0) begin n_fail++; $display("FAIL single_en_after: got %b want 0", io_en); end
      n_checks++; if (io_pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL single_pkt_cnt: got %0d want 1", io_pkt_cnt); end
   endtask

   task automatic test_backpressure();
      io_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_beat(8'h20 + 8'(i), i == 3); io_phv_in_valid = 1'b1;
         n_checks++;
         if (io_phv_in_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, io_phv_in_ready, i < 4); end
         tick();
      end
      io_phv_in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         io_ready = 1'b1;
         n_checks++; if (io_en !== 1'b1) begin n_fail++; $display("FAIL bp_en[%0d]: got %b want 1", j, io_en); end
         n_checks++; if (io_data !== exp_data(8'h20 + 8'(j))) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", j, io_data, exp_data(8'h20 + 8'(j))); end
         n_checks++; if (io_last !== (j == 3)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", j, io_last, j == 3); end
         tick();
         if (j == 0) begin
            n_checks++; if (io_phv_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b want 1", io_phv_in_ready); end
         end
      end
      n_checks++; if (io_en !== 1'b0) begin n_fail++; $display("FAIL bp_fifth_dropped: got en %b want 0", io_en); end
      n_checks++; if (io_pkt_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_pkt_cnt: got %0d want 2", io_pkt_cnt); end
   endtask

   task automatic test_streaming();
      io_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_beat(8'h40 + 8'(i), i >= 2); io_phv_in_valid = 1'b1;
         tick();
         n_checks++; if (io_en !== 1'b1) begin n_fail++; $display("FAIL stream_en[%0d]: got %b want 1", i, io_en); end
         n_checks++; if (io_data !== exp_data(8'h40 + 8'(i))) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, io_data, exp_data(8'h40 + 8'(i))); end
         n_checks++; if (io_last !== (i >= 2)) begin n_fail++; $display("FAIL stream_last[%0d]: got %b want %b", i, io_last, i >= 2); end
         n_checks++; if (io_phv_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, io_phv_in_ready); end
      end
      io_phv_in_valid = 1'b0;
      tick();
      n_checks++; if (io_en !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got %b want 0", io_en); end
      n_checks++; if (io_pkt_cnt !== 16'd4) begin n_fail++; $display("FAIL stream_pkt_cnt: got %0d want 4", io_pkt_cnt); end
   endtask

   task automatic test_back_to_back();
      int q[$];
      int sent = 0;
      int idx;
      for (int cyc = 0; cyc < 40; cyc++) begin
         io_phv_in_valid = (sent < 12);
         set_beat(8'h60 + 8'(sent), (sent % 3) == 2);
         io_ready = (cyc < 4) ? 1'b0 : 1'(cyc & 1);
         #1;
         if (io_en && io_ready) begin
            n_checks++;
            if (q.size() == 0) begin n_fail++; $display("FAIL b2b_extra_beat: got %h want none", io_data); end
            else begin
               idx = q.pop_front();
               if (io_data !== exp_data(8'h60 + 8'(idx)) || io_last !== ((idx % 3) == 2)) begin
                  n_fail++; $display("FAIL b2b_order: got last %b data %h want beat %0d", io_last, io_data, idx);
               end
            end
         end
         if (io_phv_in_valid && io_phv_in_ready) begin q.push_back(sent); sent++; end
         tick();
      end
      io_phv_in_valid = 1'b0;
      n_checks++; if (sent != 12 || q.size() != 0) begin n_fail++; $display("FAIL b2b_count: got sent %0d left %0d want 12 0", sent, q.size()); end
      n_checks++; if (io_en !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", io_en); end
   endtask

   task automatic test_wrap();
      reset = 1'b0; io_phv_in_valid = 1'b0; tick(); reset = 1'b1;
      io_ready = 1'b1; io_phv_in_valid = 1'b1; set_beat(8'h11, 1'b1);
      for (int i = 0; i < 65537; i++) tick();
      io_phv_in_valid = 1'b0; set_beat(8'h99, 1'b0);
      n_checks++; if (io_data !== exp_data(8'h11) || io_last !== 1'b1) begin n_fail++; $display("FAIL wrap_last_beat: got %b %h want 1 %h", io_last, io_data, exp_data(8'h11)); end
      tick();
      n_checks++; if (io_pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL wrap_pkt_cnt: got %0d want 1", io_pkt_cnt); end
   endtask

   task automatic test_reset_midop();
      io_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin set_beat(8'h80 + 8'(i), 1'b0); io_phv_in_valid = 1'b1; tick(); end
      io_phv_in_valid = 1'b0;
      n_checks++; if (io_en !== 1'b1) begin n_fail++; $display("FAIL midop_buffered: got %b want 1", io_en); end
      reset = 1'b0; tick(); reset = 1'b1;
      n_checks++; if (io_en !== 1'b0) begin n_fail++; $display("FAIL midop_en: got %b want 0", io_en); end
      n_checks++; if (io_phv_in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready: got %b want 1", io_phv_in_ready); end
      n_checks++; if (io_pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL midop_pkt_cnt: got %0d want 0", io_pkt_cnt); end
      n_checks++; if (io_overflow !== 1'b0) begin n_fail++; $display("FAIL midop_overflow: got %b want 0", io_overflow); end
      for (int i = 0; i < 4; i++) begin set_beat(8'hA0 + 8'(i), 1'b0); io_phv_in_valid = 1'b1; tick(); end
      set_beat(8'hB0, 1'b0); tick(); tick();
      n_checks++; if (io_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_held_stable: got %b want 0", io_overflow); end
      set_beat(8'hB1, 1'b0); tick();
      io_phv_in_valid = 1'b0;
      n_checks++; if (io_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", io_overflow); end
      n_checks++; if (io_data !== exp_data(8'hA0)) begin n_fail++; $display("FAIL ovf_head: got %h want %h", io_data, exp_data(8'hA0)); end
      tick();
      n_checks++; if (io_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", io_overflow); end
      reset = 1'b0; tick(); reset = 1'b1;
      n_checks++; if (io_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", io_overflow); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_backpressure();
      test_streaming();
      test_back_to_back();
      test_wrap();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/out_port.md
# out_port

Transmit-side port of the switch pipeline: the inverse of the ingress port. It accepts the final-stage PHV as 128 byte lanes plus valid/last, buffers beats in a small FIFO, and serialises each beat onto the 1024-bit egress data bus with en/last under downstream backpressure. It sits after the last match-action stage and drives the egress MAC/stream interface.

## Interface
- DEPTH, 4: FIFO depth in beats; power of two, ≥2.
- clock  input  1  sole clock; all state on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clock.
- io_phv_in_data_0 … io_phv_in_data_127  input  8 each  PHV byte lanes.
- io_phv_in_valid  input  1  upstream beat valid.
- io_phv_in_last  input  1  beat is last of packet.
- io_phv_in_ready  output  1  block can accept a beat this cycle.
- io_ready  input  1  egress sink can accept a beat.
- io_en  output  1  egress beat valid.
- io_last  output  1  egress beat is last of packet.
- io_data  output  1024  egress beat data.
- io_pkt_cnt  output  16  packets fully transmitted (wraps).
- io_overflow  output  1  sticky: valid asserted while ready low and data changed (protocol violation flag).

## Operation
- Packing: lane k maps to io_data[1023-8k : 1016-8k]; lane 0 in [1023:1016], lane 127 in [7:0]. io_last carries the entry's last bit unchanged.
- Storage: DEPTH-entry circular FIFO of {last, 1024-bit data}; write pointer, read pointer (log2(DEPTH) bits, wrap mod DEPTH), occupancy count 0…DEPTH.
- Push: io_phv_in_valid & io_phv_in_ready. io_phv_in_ready = (count < DEPTH), combinational from registered count only; no dependency on io_ready.
- Pop: io_en & io_ready. io_en = (count > 0). io_data/io_last are the head entry, driven from registered storage (no combinational path from PHV inputs to outputs).
- Simultaneous push and pop: count unchanged, both pointers advance. At count = DEPTH, push is refused even if a pop occurs that cycle.
- io_pkt_cnt increments by 1 on each pop with head last = 1; 0xFFFF wraps to 0x0000.
- io_overflow: set when, in consecutive cycles, io_phv_in_valid = 1, io_phv_in_ready = 0 and any lane or last differs from previous cycle; cleared only by reset.
- Beats are forwarded in order; no reordering, merging, or dropping. Packets with only one beat (last on first beat) are legal.

## Timing
- Reset (reset = 0 at an edge): count, pointers, io_pkt_cnt, io_overflow ← 0. During and after reset: io_en = 0, io_phv_in_ready = 1, io_last = 0, io_data = 0 (storage entry 0 cleared; other entries don't care since io_en = 0).
- Reset mid-packet discards all buffered beats; the partial packet is not counted.
- Latency: beat pushed at edge N into empty FIFO appears with io_en = 1 in cycle after N (1 cycle).
- Throughput: one beat per cycle sustained when io_ready held high.
- io_en, once high, stays high with io_data/io_last stable until popped (standard valid/ready hold).
- io_phv_in_ready falls in the cycle after the push that makes count = DEPTH; rises in the cycle after the first subsequent pop.

## Test plan
- Single beat: lanes = k (byte value k), last = 1, io_ready = 1 -> next cycle io_en = 1, io_data[1023:1016] = 0x00, io_data[7:0] = 0x7F, io_last = 1; following cycle io_en = 0, io_pkt_cnt = 1.
- Backpressure fill: io_ready = 0, push 5 beats (DEPTH = 4) -> 4 accepted, io_phv_in_ready = 0 after 4th; release io_ready -> 4 beats out in order, one per cycle, ready reasserts one cycle after first pop.
- Streaming: 3-beat packet then 1-beat packet, io_ready = 1 continuously -> 4 consecutive io_en cycles, io_last on beats 3 and 4, io_pkt_cnt = 2, count never exceeds 1.
- Simultaneous push/pop at full with io_ready toggling every cycle -> no beat lost or duplicated; output sequence equals input sequence.
- Wrap: 65537 one-beat packets -> io_pkt_cnt = 1; pointers wrap with data intact.
- Reset mid-operation: 2 beats buffered, pull reset low one edge -> io_en = 0, io_phv_in_ready = 1, io_pkt_cnt = 0, io_overflow = 0 next cycle; changing data while stalled at full sets io_overflow = 1.
